// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared register map, mode encodings and rotate helpers for the
//            LED pattern engine.
// Revision : 1.0
// ============================================================================
package led_pkg;

   localparam logic [7:0] ADDR_PAT_LO = 8'h01;
   localparam logic [7:0] ADDR_PAT_HI = 8'h02;
   localparam logic [7:0] ADDR_CTRL   = 8'h03;
   localparam logic [7:0] ADDR_DIV    = 8'h04;
   localparam logic [7:0] ADDR_DUTY   = 8'h05;

   localparam int CTRL_EN = 2;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_ROTL   = 2'b10,
      MODE_ROTR   = 2'b11
   } mode_e;

   function automatic logic [15:0] rotl16(input logic [15:0] v);
      return {v[14:0], v[15]};
   endfunction

   function automatic logic [15:0] rotr16(input logic [15:0] v);
      return {v[0], v[15:1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_tick_gen
// Purpose  : Prescaler plus step divider; flags the cycle on which a pattern
//            step occurs.
// Revision : 1.0
// ============================================================================
module led_tick_gen
   import led_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int DIV_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             step
);

   localparam int             PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] r_pre;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_div_last;
   logic             w_tick;
   logic             w_wrap;

   // DIV=0 behaves as 1; >= keeps the counter bounded if DIV shrinks mid-count
   assign w_div_last = (div == '0) ? '0 : div - DIV_W'(1);
   assign w_tick     = (r_pre == PRE_LAST);
   assign w_wrap     = (r_cnt >= w_div_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else if (!enable || clear) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
         r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
      end else begin
         r_pre <= r_pre + PRE_W'(1);
      end
   end

   assign step = enable & ~clear & w_tick & w_wrap;

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_engine
// Purpose  : Memory-mapped 16-bit LED pattern peripheral (static, blink,
//            rotate-left, rotate-right). Optional PWM dimming when
//            LED_PATTERN_PWM_EN is defined.
// Revision : 1.0
// ============================================================================
module led_pattern_engine
   import led_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int DIV_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [7:0]  data_address,
   input  logic [7:0]  write_data,
   input  logic        rd_en,
   output logic [7:0]  rd_data,
   output logic [15:0] led,
   output logic        step_pulse
);

   logic [15:0]      r_base;
   logic [15:0]      r_work;
   logic [2:0]       r_ctrl;
   logic [DIV_W-1:0] r_div;
   logic             r_phase;

   mode_e       w_mode;
   logic        w_en;
   logic        w_lo_chg;
   logic        w_hi_chg;
   logic        w_ctrl_chg;
   logic        w_wr_div;
   logic        w_step;
   logic [15:0] w_led_nxt;
   logic [15:0] w_led_out;
   logic [7:0]  w_rd_val;

   assign w_mode = mode_e'(r_ctrl[1:0]);
   assign w_en   = r_ctrl[CTRL_EN];

   // Only writes that actually change a value disturb the pattern, so a
   // sequencer holding wr_en high on the same data is harmless.
   assign w_lo_chg   = wr_en && (data_address == ADDR_PAT_LO) && (write_data != r_base[7:0]);
   assign w_hi_chg   = wr_en && (data_address == ADDR_PAT_HI) && (write_data != r_base[15:8]);
   assign w_ctrl_chg = wr_en && (data_address == ADDR_CTRL)   && (write_data[2:0] != r_ctrl);
   assign w_wr_div   = wr_en && (data_address == ADDR_DIV);

   led_tick_gen #(
      .PRESCALE (PRESCALE),
      .DIV_W    (DIV_W)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (w_en),
      .clear  (w_ctrl_chg),
      .div    (r_div),
      .step   (w_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base  <= '0;
         r_work  <= '0;
         r_ctrl  <= '0;
         r_div   <= DIV_W'(1);
         r_phase <= 1'b0;
      end else begin
         // A state-changing write takes priority over a coincident step
         if (w_lo_chg) begin
            r_base[7:0] <= write_data;
            r_work      <= {r_base[15:8], write_data};
            r_phase     <= 1'b0;
         end else if (w_hi_chg) begin
            r_base[15:8] <= write_data;
            r_work       <= {write_data, r_base[7:0]};
            r_phase      <= 1'b0;
         end else if (w_ctrl_chg) begin
            r_ctrl  <= write_data[2:0];
            r_work  <= r_base;
            r_phase <= 1'b0;
         end else if (w_step) begin
            case (w_mode)
               MODE_BLINK: r_phase <= ~r_phase;
               MODE_ROTL:  r_work  <= rotl16(r_work);
               MODE_ROTR:  r_work  <= rotr16(r_work);
               default:    r_work  <= r_work;
            endcase
         end
         if (w_wr_div) begin
            r_div <= DIV_W'(write_data);
         end
      end
   end

   always_comb begin
      w_led_nxt = '0;
      if (w_en) begin
         if (w_mode == MODE_BLINK) begin
            w_led_nxt = r_phase ? 16'h0000 : r_base;
         end else begin
            w_led_nxt = r_work;
         end
      end
   end

`ifdef LED_PATTERN_PWM_EN
   logic [7:0] r_duty;
   logic [7:0] r_pwm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty <= 8'hFF;
         r_pwm  <= 8'h00;
      end else begin
         r_pwm <= r_pwm + 8'd1;
         if (wr_en && (data_address == ADDR_DUTY)) begin
            r_duty <= write_data;
         end
      end
   end

   assign w_led_out = w_led_nxt & {16{r_pwm < r_duty}};
`else
   assign w_led_out = w_led_nxt;
`endif

   always_comb begin
      w_rd_val = 8'h00;
      case (data_address)
         ADDR_PAT_LO: w_rd_val = r_base[7:0];
         ADDR_PAT_HI: w_rd_val = r_base[15:8];
         ADDR_CTRL:   w_rd_val = {5'b00000, r_ctrl};
         ADDR_DIV:    w_rd_val = 8'(r_div);
`ifdef LED_PATTERN_PWM_EN
         ADDR_DUTY:   w_rd_val = r_duty;
`endif
         default:     w_rd_val = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led        <= '0;
         rd_data    <= '0;
         step_pulse <= 1'b0;
      end else begin
         led        <= w_led_out;
         step_pulse <= w_step;
         if (rd_en) begin
            rd_data <= w_rd_val;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_engine
// Purpose  : Scoreboard bench for led_pattern_engine with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_led_pattern_engine;

   localparam int P = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  data_address = 8'h00;
   logic [7:0]  write_data = 8'h00;
   logic [7:0]  rd_data;
   logic [15:0] led;
   logic        step_pulse;

   always #5 clk = ~clk;

   led_pattern_engine #(.PRESCALE(P), .DIV_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .data_address (data_address),
      .write_data   (write_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .led          (led),
      .step_pulse   (step_pulse)
   );

   typedef struct {
      logic [15:0] led;
      logic        sp;
      logic [7:0]  rd;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Behavioural model state: registers, elapsed enabled cycles, ticks since last step
   logic [15:0] m_base, m_work;
   logic [7:0]  m_ctrl, m_div, m_rd, m_duty, m_pwm;
   logic        m_phase;
   int          m_el, m_tk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_base = 0; m_work = 0; m_ctrl = 0; m_div = 1; m_rd = 0;
      m_duty = 8'hFF; m_pwm = 0; m_phase = 0; m_el = 0; m_tk = 0;
   endtask

   function automatic int eff_div();
      return (m_div == 0) ? 1 : int'(m_div);
   endfunction

   function automatic bit model_step_next();
      return m_ctrl[2] && (m_el % P == P - 1) && (m_tk + 1 >= eff_div());
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] a);
      case (a)
         8'h01: return m_base[7:0];
         8'h02: return m_base[15:8];
         8'h03: return m_ctrl;
         8'h04: return m_div;
`ifdef LED_PATTERN_PWM_EN
         8'h05: return m_duty;
`endif
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_edge(input bit we, input logic [7:0] a, input logic [7:0] d, input bit re);
      exp_t e;
      logic [15:0] shown;
      bit st, chg_pat, chg_ctrl;
      shown = 16'h0000;
      if (m_ctrl[2]) shown = (m_ctrl[1:0] == 2'b01) ? (m_phase ? 16'h0000 : m_base) : m_work;
`ifdef LED_PATTERN_PWM_EN
      if (!(m_pwm < m_duty)) shown = 16'h0000;
      m_pwm = m_pwm + 8'd1;
`endif
      if (re) m_rd = model_read(a);
      st       = model_step_next();
      chg_ctrl = we && (a == 8'h03) && (d[2:0] != m_ctrl[2:0]);
      chg_pat  = we && (((a == 8'h01) && (d != m_base[7:0])) || ((a == 8'h02) && (d != m_base[15:8])));
      e.sp = st && !chg_ctrl;
      if (!m_ctrl[2] || chg_ctrl) begin
         m_el = 0; m_tk = 0;
      end else begin
         if (m_el % P == P - 1) m_tk = (m_tk + 1 >= eff_div()) ? 0 : m_tk + 1;
         m_el++;
      end
      if (chg_pat) begin
         if (a == 8'h01) m_base[7:0] = d; else m_base[15:8] = d;
         m_work = m_base; m_phase = 0;
      end else if (chg_ctrl) begin
         m_ctrl = {5'b0, d[2:0]}; m_work = m_base; m_phase = 0;
      end else if (st) begin
         case (m_ctrl[1:0])
            2'b01: m_phase = ~m_phase;
            2'b10: m_work = (m_work << 1) | (m_work >> 15);
            2'b11: m_work = (m_work >> 1) | (m_work << 15);
            default: ;
         endcase
      end
      if (we && a == 8'h04) m_div = d;
`ifdef LED_PATTERN_PWM_EN
      if (we && a == 8'h05) m_duty = d;
`endif
      e.led = shown;
      e.rd  = m_rd;
      q.push_back(e);
   endtask

   task automatic cycle(input bit we, input logic [7:0] a, input logic [7:0] d, input bit re);
      wr_en = we; data_address = a; write_data = d; rd_en = re;
      @(posedge clk);
      model_edge(we, a, d, re);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic async_reset();
      wr_en = 0; rd_en = 0; data_address = 0; write_data = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_led", 32'(led), 32'h0);
      chk("async_rd", 32'(rd_data), 32'h0);
      chk("async_step", 32'(step_pulse), 32'h0);
      q.delete();
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Monitor: one expected entry per clock edge out of reset
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("led", 32'(led), 32'(e.led));
            chk("step_pulse", 32'(step_pulse), 32'(e.sp));
            chk("rd_data", 32'(rd_data), 32'(e.rd));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_led", 32'(led), 32'h0);
      chk("reset_rd", 32'(rd_data), 32'h0);
      #2 rst_n = 1'b1;

      // Reset values readback
      cycle(0, 8'h03, 8'h00, 1);
      cycle(0, 8'h04, 8'h00, 1);

      // Static
      cycle(1, 8'h01, 8'h05, 0);
      cycle(1, 8'h02, 8'hA0, 0);
      cycle(1, 8'h03, 8'h04, 0);
      idle(14);

      // Rotate-left with held identical PAT_LO rewrites
      cycle(1, 8'h01, 8'h01, 0);
      cycle(1, 8'h02, 8'h00, 0);
      cycle(1, 8'h04, 8'h02, 0);
      cycle(1, 8'h03, 8'h06, 0);
      for (int i = 0; i < 40; i++) cycle(1, 8'h01, 8'h01, 0);
      cycle(0, 8'h03, 8'h00, 1);
      idle(3);
      async_reset();
      cycle(0, 8'h03, 8'h00, 1);
      cycle(0, 8'h04, 8'h00, 1);

      // Blink, then a PAT_LO write landing on a step edge
      cycle(1, 8'h01, 8'hFF, 0);
      cycle(1, 8'h02, 8'h00, 0);
      cycle(1, 8'h04, 8'h01, 0);
      cycle(1, 8'h03, 8'h05, 0);
      idle(17);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (model_step_next()) found = 1;
         else idle(1);
      end
      chk("collision_step_found", 32'(found), 32'h1);
      cycle(1, 8'h01, 8'h0F, 0);
      idle(12);

      // Unmapped access and DIV=0
      cycle(1, 8'h07, 8'hFF, 0);
      cycle(0, 8'h07, 8'h00, 1);
      cycle(0, 8'h01, 8'h00, 1);
      cycle(1, 8'h04, 8'h00, 0);
      cycle(1, 8'h03, 8'h06, 0);
      idle(20);
      cycle(0, 8'h04, 8'h00, 1);

      // PWM dimming (address 0x05 is unmapped without the feature)
      cycle(1, 8'h01, 8'hFF, 0);
      cycle(1, 8'h02, 8'hFF, 0);
      cycle(1, 8'h03, 8'h04, 0);
      cycle(1, 8'h05, 8'h40, 0);
      idle(300);
      cycle(0, 8'h05, 8'h00, 1);
      cycle(1, 8'h05, 8'h00, 0);
      idle(40);
      cycle(1, 8'h05, 8'hFF, 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] a, d;
         bit we, re;
         we = ($urandom % 8) == 0;
         re = ($urandom % 4) == 0;
         a  = 8'($urandom % 8);
         d  = 8'($urandom);
         if (a == 8'h04) d = 8'($urandom % 4);
         if (a == 8'h03 && ($urandom % 2) == 1) d[2] = 1'b1;
         cycle(we, a, d, re);
      end

      idle(2);
      #1;
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Memory-mapped LED pattern peripheral; sits directly downstream of the ROM write sequencer.
- Consumes the sequencer's single-cycle-qualified write bus (wr_en, data_address, write_data) and drives a 16-bit LED bank.
- Display modes: static, blink, rotate-left, rotate-right.
- Step rate is set by a programmable tick divider.

Parameters:
- PRESCALE, 50000: clk cycles per prescaler tick; legal range is 1 or more.
- DIV_W, 8: width of the step-divider register and counter.

Ports:
- clk  in  1  system clock. One clock; all logic uses its rising edge.
- rst_n  in  1  reset. Reset is asynchronous and active-low.
- wr_en  in  1  write qualifier, sampled every clk edge.
- data_address  in  8  register address.
- write_data  in  8  write payload.
- rd_en  in  1  read request.
- rd_data  out  8  registered read data.
- led  out  16  registered LED drive.
- step_pulse  out  1  one-cycle pulse on each pattern step (debug/verification).

Behaviour:
- Register map:
  - 0x01 PAT_LO: base pattern [7:0].
  - 0x02 PAT_HI: base pattern [15:8].
  - 0x03 CTRL: [1:0] mode (00 static, 01 blink, 10 rotl, 11 rotr), [2] enable, [7:3] reserved; write 0, read 0.
  - 0x04 DIV: prescaler ticks per step.
  - Any other address: writes ignored, reads return 0x00.
- Reset, asynchronous on rst_n low, takes effect immediately with no clock needed:
  - base=0x0000, work=0x0000, CTRL=0x00, DIV=0x01.
  - prescaler=0, step counter=0, phase=0.
  - led=0, rd_data=0, step_pulse=0.
- Write acceptance:
  - Every edge with wr_en=1 is a write. The upstream sequencer may hold wr_en high across many cycles, so repeated writes must be harmless.
  - PAT_LO/PAT_HI write: update the base half. Reload work from the new base and clear phase only if the written byte differs from the stored byte. An identical rewrite does not disturb rotation or blink.
  - CTRL write: if the value differs from stored, clear prescaler, step counter and phase, and reload work from base.
  - DIV write: update DIV; counters are not cleared. DIV=0 is treated as 1.
- Tick/step generation:
  - Active only while enable=1; while enable=0, prescaler and step counter are held at 0.
  - Prescaler counts 0..PRESCALE-1 and emits a tick on the wrap.
  - Step counter counts ticks 0..max(DIV,1)-1; on wrap, step_pulse=1 for exactly one cycle.
- On a step:
  - static: no change.
  - blink: phase toggles.
  - rotl: work <= {work[14:0],work[15]}.
  - rotr: work <= {work[0],work[15:1]}.
- If a step and a state-changing write land on the same edge, the write wins and the step is discarded.
- LED output, registered:
  - led <= 0 if enable=0.
  - Otherwise, blink mode: led <= phase ? 0x0000 : base.
  - Otherwise, all other modes: led <= work.
- Latency:
  - Write at edge N becomes visible on led at edge N+1.
  - Step at edge N (step_pulse high after N) becomes visible on led at edge N+1.
- Read: rd_en at edge N gives rd_data valid after edge N (register contents at N), held until the next rd_en. Reads have no side effects.
- Rotation wraps modulo 16. The counters never overflow because each one wraps at its terminal count.

Optional Feature:
- Macro: LED_PATTERN_PWM_EN.
- Defined:
  - Adds register 0x05 DUTY (reset 0xFF).
  - Adds a free-running 8-bit pwm counter.
  - The led result is ANDed with {16{pwm_cnt < DUTY}}. DUTY=0 forces LEDs off; DUTY=0xFF gives 255/256 on-time.
  - 0x05 is readable.
- Not defined: address 0x05 is unmapped, and led is exactly as specified above.

Decomposition:
- Shared package led_pkg:
  - Address constants ADDR_PAT_LO=8'h01, ADDR_PAT_HI=8'h02, ADDR_CTRL=8'h03, ADDR_DIV=8'h04, ADDR_DUTY=8'h05.
  - Mode encodings MODE_STATIC/BLINK/ROTL/ROTR.
  - CTRL bit index CTRL_EN=2.
- One sub-module, led_tick_gen:
  - Contains the prescaler and divider.
  - Inputs: clk, rst_n, enable, clear, div.
  - Output: step pulse.

Test Plan (PRESCALE=4 in bench):
- Reset mid-run: assert rst_n low between edges while in rotl -> led=0x0000 and rd_data=0 immediately; after release, reading CTRL gives 0x00 and DIV gives 0x01.
- Static: write 0x01=0x05, 0x02=0xA0, 0x03=0x04 -> led=0xA005 one edge after the CTRL write; step_pulse every 4 cycles; led unchanged.
- Rotate with held wr_en: write 0x01=0x01, 0x02=0x00, DIV=2, CTRL=0x06, then hold wr_en=1 with addr 0x01, data 0x01 -> led steps 0x0001, 0x0002, 0x0004 every 8 cycles. The rewrites must not reload work.
- Blink plus collision: base=0x00FF, CTRL=0x05, DIV=1 -> led alternates 0x00FF/0x0000 every 4 cycles. A PAT_LO=0x0F write on a step edge makes led 0x000F with phase 0 and no toggle.
- Unmapped/DIV=0: write 0x07=0xFF, then read 0x07 -> 0x00, no state change. DIV=0 behaves identically to DIV=1.
- PWM (macro defined): DUTY=0x40, static 0xFFFF -> led high 64 of every 256 cycles; DUTY=0 -> led constant 0.
